nx_node_egress: RTL and testbench

Outbound message stage directly downstream of the node execution core. It accepts SIGNAL messages from the core's send interface and buffers them in a small FIFO. Using the header target ID, it routes each message onto one of the node's four mesh output ports (north/east/south/west), or onto a local loopback port when the target is this node. It isolates the core from mesh backpressure, so core stalls only occur when the FIFO is full.

---
 rtl/nx_node_egress_if.sv | 22 ++
 rtl/nx_node_egress.sv | 65 ++++++
 tb/tb_nx_node_egress.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nx_node_egress_if.sv
// nx_node_egress_if: node message types plus valid/ready message channel (master drives data/valid, slave drives ready)
package nx_node_pkg;
  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } node_id_t;
  typedef struct packed {
    node_id_t    target;
    node_id_t    source;
    logic [7:0]  kind;
    logic [31:0] payload;
  } node_message_t;
endpackage

interface nx_node_egress_if;
  import nx_node_pkg::*;
  node_message_t data;
  logic          valid;
  logic          ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/nx_node_egress.sv
// nx_node_egress: buffers core messages in a FIFO and routes the head column-first to N/E/S/W/local; ports: i_clk, i_rst (sync active-low), i_node_id, i_msg (slave), o_north/o_east/o_south/o_west/o_local (master), o_idle
module nx_node_egress
  import nx_node_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  node_id_t         i_node_id,
  nx_node_egress_if.slave  i_msg,
  nx_node_egress_if.master o_north,
  nx_node_egress_if.master o_east,
  nx_node_egress_if.master o_south,
  nx_node_egress_if.master o_west,
  nx_node_egress_if.master o_local,
  output logic             o_idle
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  node_message_t r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  node_message_t w_head;
  logic w_any, w_push, w_pop;
  logic w_east, w_west, w_south, w_north, w_local;
  always_comb begin
    w_head  = r_mem[r_rd_ptr];
    w_any   = r_count != '0;
    w_east  = w_head.target.col > i_node_id.col;
    w_west  = w_head.target.col < i_node_id.col;
    w_south = w_head.target.col == i_node_id.col && w_head.target.row > i_node_id.row;
    w_north = w_head.target.col == i_node_id.col && w_head.target.row < i_node_id.row;
    w_local = w_head.target == i_node_id;
  end
  assign i_msg.ready   = r_count < FULL;
  assign w_push        = i_msg.valid && i_msg.ready;
  assign o_north.valid = w_any && w_north;
  assign o_east.valid  = w_any && w_east;
  assign o_south.valid = w_any && w_south;
  assign o_west.valid  = w_any && w_west;
  assign o_local.valid = w_any && w_local;
  assign o_north.data  = w_head;
  assign o_east.data   = w_head;
  assign o_south.data  = w_head;
  assign o_west.data   = w_head;
  assign o_local.data  = w_head;
  assign w_pop = (o_north.valid && o_north.ready) || (o_east.valid && o_east.ready) ||
                 (o_south.valid && o_south.ready) || (o_west.valid && o_west.ready) ||
                 (o_local.valid && o_local.ready);
  assign o_idle = !w_any && !i_msg.valid;
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_msg.data;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_nx_node_egress.sv
// tb_nx_node_egress: scoreboard bench with a queue-based reference model and random plus directed stimulus
module tb_nx_node_egress;
  import nx_node_pkg::*;
  logic clk = 0;
  logic rst = 0;
  logic idle;
  node_id_t node_id;
  always #5 clk = ~clk;
  nx_node_egress_if m_in(), m_n(), m_e(), m_s(), m_w(), m_l();
  nx_node_egress #(.FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_node_id(node_id), .i_msg(m_in),
    .o_north(m_n), .o_east(m_e), .o_south(m_s), .o_west(m_w), .o_local(m_l),
    .o_idle(idle)
  );
  int errors = 0;
  int checks = 0;
  node_message_t q[$];
  bit armed = 0;
  // 0 north, 1 east, 2 south, 3 west, 4 local
  function automatic int route_of(node_message_t m, node_id_t own);
    if (m.target.col > own.col) return 1;
    if (m.target.col < own.col) return 3;
    if (m.target.row > own.row) return 2;
    if (m.target.row < own.row) return 0;
    return 4;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    logic [4:0] v, r, ev;
    node_message_t d [5];
    v = {m_l.valid, m_w.valid, m_s.valid, m_e.valid, m_n.valid};
    r = {m_l.ready, m_w.ready, m_s.ready, m_e.ready, m_n.ready};
    d = '{m_n.data, m_e.data, m_s.data, m_w.data, m_l.data};
    ev = q.size() != 0 ? 5'(1 << route_of(q[0], node_id)) : 5'b0;
    if (armed) begin
      chk("valid_vec", 64'(v), 64'(ev));
      chk("msg_ready", 64'(m_in.ready), 64'(q.size() < 4));
      chk("idle", 64'(idle), 64'(q.size() == 0 && !m_in.valid));
      for (int i = 0; i < 5; i++)
        if (ev[i]) chk("head_data", 64'(d[i]), 64'(q[0]));
    end
    if (!rst) begin
      q.delete();
      armed = 1;
    end else if (armed) begin
      if ((ev & r) != 0) void'(q.pop_front());
      if (m_in.valid && m_in.ready) q.push_back(m_in.data);
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic node_message_t mk(int row, int col);
    node_message_t m;
    m.target.row = 4'(row);
    m.target.col = 4'(col);
    m.source     = 8'($urandom);
    m.kind       = 8'($urandom);
    m.payload    = $urandom;
    return m;
  endfunction
  task automatic set_rdy(logic [4:0] r);
    {m_l.ready, m_w.ready, m_s.ready, m_e.ready, m_n.ready} = r;
  endtask
  task automatic push(node_message_t m);
    int b = 0;
    m_in.data  = m;
    m_in.valid = 1;
    @(negedge clk);
    while (!m_in.ready && b < 200) begin
      b++;
      @(negedge clk);
    end
    if (!m_in.ready) begin
      errors++;
      checks++;
      $display("FAIL push_timeout: ready=%b required 1", m_in.ready);
    end
    @(posedge clk);
    #1;
    m_in.valid = 0;
  endtask
  task automatic drain();
    int b = 0;
    set_rdy(5'h1f);
    while (q.size() != 0 && b < 200) begin
      b++;
      tick();
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: left=%0d required 0", q.size());
    end
    tick();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    m_in.valid = 0;
    m_in.data  = '0;
    set_rdy(5'h1f);
    node_id = '{row: 4'd2, col: 4'd2};
    tick(2);
    rst = 1;
    tick();
    push(mk(2, 3)); push(mk(2, 1)); push(mk(3, 2)); push(mk(1, 2)); push(mk(2, 2));
    drain();
    set_rdy(5'h1d);
    fork
      for (int i = 0; i < 6; i++) push(mk(2, 3));
      begin tick(10); m_e.ready = 1; end
    join
    drain();
    set_rdy(5'h1e);
    push(mk(1, 2));
    push(mk(2, 2));
    tick(5);
    m_n.ready = 1;
    drain();
    set_rdy(5'h1d);
    push(mk(2, 3));
    push(mk(2, 3));
    m_e.ready = 1;
    for (int i = 0; i < 8; i++) push(mk(2, 3));
    drain();
    set_rdy(5'h00);
    push(mk(2, 3)); push(mk(1, 2)); push(mk(2, 2));
    rst = 0;
    tick();
    rst = 1;
    tick(3);
    set_rdy(5'h1f);
    tick(5);
    set_rdy(5'h00);
    push(mk(3, 3));
    m_in.data  = mk(2, 2);
    m_in.valid = 1;
    rst = 0;
    tick();
    rst = 1;
    m_in.valid = 0;
    set_rdy(5'h1f);
    tick(5);
    node_id = '{row: 4'd0, col: 4'd0};
    set_rdy(5'h1b);
    push(mk(5, 7));
    tick(2);
    drain();
    for (int round = 0; round < 5; round++) begin
      node_id = '{row: 4'($urandom_range(0, 3)), col: 4'($urandom_range(0, 3))};
      for (int c = 0; c < 300; c++) begin
        set_rdy(5'($urandom));
        m_in.data  = mk($urandom_range(0, 3), $urandom_range(0, 3));
        m_in.valid = ($urandom_range(0, 1) == 1);
        if (c == 150 && round == 2) rst = 0;
        tick();
        rst = 1;
      end
      m_in.valid = 0;
      drain();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
